// File: rtl/bsg_manycore_npa_to_eva.sv
// Reverse address translator: network physical address (x, y, word EPA) back to the
// 32-bit byte EVA a vanilla core would have issued, over a 2-stage valid/ready pipeline.
module bsg_manycore_npa_to_eva #(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 6,
    parameter int y_cord_width_p               = 6,
    parameter int num_tiles_x_p                = 16,
    parameter int num_tiles_y_p                = 8,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_size_p                = 4096,
    parameter int epa_word_addr_width_p        = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    output logic                      ready_o,
    input  logic [x_cord_width_p-1:0] x_cord_i,
    input  logic [y_cord_width_p-1:0] y_cord_i,
    input  logic [addr_width_p-1:0]   epa_i,
    input  logic                      dram_enable_i,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic [data_width_p-1:0]   eva_o,
    output logic                      is_dram_o,
    output logic                      is_invalid_o
);

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_DRAM    = 2'd1,
        CLS_HOST    = 2'd2,
        CLS_GLOBAL  = 2'd3
    } npa_class_e;

    typedef struct packed {
        logic                    invalid;
        logic [data_width_p-1:0] eva;
    } eva_result_t;

    localparam int X_BITS    = $clog2(num_tiles_x_p);
    localparam int BANK_W    = X_BITS + 1;
    localparam int BLK_W     = $clog2(vcache_block_size_in_words_p);
    localparam int INDEX_W   = data_width_p - 1 - BANK_W - BLK_W - 2;
    localparam int EN_TOP    = BLK_W + INDEX_W;
    localparam int VC_W      = $clog2(vcache_size_p);
    localparam int DIS_PAD_W = data_width_p - 2 - 1 - X_BITS - VC_W - 2;
    localparam int HOST_W    = data_width_p - 5;
    localparam int GCORD_W   = 6;

    localparam logic [x_cord_width_p-1:0] NUM_X = x_cord_width_p'(num_tiles_x_p);
    localparam logic [y_cord_width_p-1:0] BOT_Y = y_cord_width_p'(num_tiles_y_p + 1);
    localparam logic [y_cord_width_p-1:0] HOST_Y = y_cord_width_p'(1);

    function automatic npa_class_e classify(
        input logic                      dram_en,
        input logic [x_cord_width_p-1:0] x,
        input logic [y_cord_width_p-1:0] y,
        input logic [addr_width_p-1:0]   epa
    );
        npa_class_e cls;
        cls = CLS_INVALID;
        if (!dram_en && (y == HOST_Y) && (x == '0) && epa[addr_width_p-1])
            cls = CLS_HOST;
        else if (((y == '0) || (y == BOT_Y)) && (x < NUM_X) && !epa[addr_width_p-1])
            cls = CLS_DRAM;
        else if (((epa >> epa_word_addr_width_p) == '0)
                 && ((x >> GCORD_W) == '0) && ((y >> GCORD_W) == '0))
            cls = CLS_GLOBAL;
        return cls;
    endfunction

    function automatic eva_result_t build_eva(
        input npa_class_e                cls,
        input logic                      dram_en,
        input logic [x_cord_width_p-1:0] x,
        input logic [y_cord_width_p-1:0] y,
        input logic [addr_width_p-1:0]   epa
    );
        eva_result_t res;
        logic        bot;
        res.invalid = 1'b0;
        res.eva     = '0;
        bot         = (y == BOT_Y);
        case (cls)
            CLS_DRAM: begin
                if (dram_en) begin
                    // Identity interleave: bank sits directly below the line index.
                    if ((epa >> EN_TOP) != '0)
                        res.invalid = 1'b1;
                    else
                        res.eva = {1'b1, epa[BLK_W +: INDEX_W], bot, x[X_BITS-1:0],
                                   epa[BLK_W-1:0], 2'b00};
                end else begin
                    if ((epa >> VC_W) != '0)
                        res.invalid = 1'b1;
                    else
                        res.eva = {1'b1, 1'b0, {DIS_PAD_W{1'b0}}, bot, x[X_BITS-1:0],
                                   epa[VC_W-1:0], 2'b00};
                end
            end
            CLS_HOST: begin
                res.eva = {2'b11, 1'b0, epa[HOST_W-1:0], 2'b00};
            end
            CLS_GLOBAL: begin
                res.eva = {2'b01, y[GCORD_W-1:0], x[GCORD_W-1:0],
                           epa[epa_word_addr_width_p-1:0], 2'b00};
            end
            default: begin
                res.invalid = 1'b1;
            end
        endcase
        if (res.invalid)
            res.eva = '0;
        return res;
    endfunction

    logic                      vld_p1;
    logic                      vld_p2;
    logic                      s2_ready;
    logic                      s1_advance;
    logic                      accept;

    npa_class_e                cls_p1;
    logic [x_cord_width_p-1:0] x_p1;
    logic [y_cord_width_p-1:0] y_p1;
    logic [addr_width_p-1:0]   epa_p1;
    logic                      dram_en_p1;
    eva_result_t               res_p1;

    logic [data_width_p-1:0]   eva_p2;
    logic                      is_dram_p2;
    logic                      is_invalid_p2;

    assign s2_ready   = ~vld_p2 | ready_i;
    assign s1_advance = vld_p1 & s2_ready;
    assign ready_o    = ~vld_p1 | s1_advance;
    assign accept     = v_i & ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ready_o)
                vld_p1 <= v_i;
            if (s2_ready)
                vld_p2 <= vld_p1;
        end
    end

    // Stage 1: capture fields and decode the address class
    always_ff @(posedge clk_i) begin
        if (accept) begin
            cls_p1     <= classify(dram_enable_i, x_cord_i, y_cord_i, epa_i);
            x_p1       <= x_cord_i;
            y_p1       <= y_cord_i;
            epa_p1     <= epa_i;
            dram_en_p1 <= dram_enable_i;
        end
    end

    assign res_p1 = build_eva(cls_p1, dram_en_p1, x_p1, y_p1, epa_p1);

    // Stage 2: assembled EVA and flags
    always_ff @(posedge clk_i) begin
        if (s1_advance) begin
            eva_p2        <= res_p1.eva;
            is_invalid_p2 <= res_p1.invalid;
            is_dram_p2    <= ~res_p1.invalid & res_p1.eva[data_width_p-1];
        end
    end

    // Data registers are not reset, so outputs are qualified by the stage valid.
    assign v_o          = vld_p2;
    assign eva_o        = vld_p2 ? eva_p2 : '0;
    assign is_dram_o    = vld_p2 & is_dram_p2;
    assign is_invalid_o = vld_p2 & is_invalid_p2;

endmodule

// File: tb/tb_bsg_manycore_npa_to_eva.sv
// Scoreboard bench for bsg_manycore_npa_to_eva: directed NPAs with hand-computed EVAs,
// decoupled monitor, back-pressure and asynchronous reset scenarios.
module tb_bsg_manycore_npa_to_eva;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [5:0]  x_cord_i;
    logic [5:0]  y_cord_i;
    logic [27:0] epa_i;
    logic        dram_enable_i;
    logic        v_o;
    logic        ready_i;
    logic [31:0] eva_o;
    logic        is_dram_o;
    logic        is_invalid_o;

    bsg_manycore_npa_to_eva dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .x_cord_i      (x_cord_i),
        .y_cord_i      (y_cord_i),
        .epa_i         (epa_i),
        .dram_enable_i (dram_enable_i),
        .v_o           (v_o),
        .ready_i       (ready_i),
        .eva_o         (eva_o),
        .is_dram_o     (is_dram_o),
        .is_invalid_o  (is_invalid_o)
    );

    typedef struct {
        logic [31:0] eva;
        logic        dram;
        logic        inv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] x, input logic [5:0] y, input logic [27:0] epa,
                        input logic den, input logic [31:0] e_eva, input logic e_dram,
                        input logic e_inv, input bit push);
        exp_t e;
        bit   done;
        done          = 0;
        v_i           = 1'b1;
        x_cord_i      = x;
        y_cord_i      = y;
        epa_i         = epa;
        dram_enable_i = den;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ready_o) begin
                if (push) begin
                    e.eva  = e_eva;
                    e.dram = e_dram;
                    e.inv  = e_inv;
                    exp_q.push_back(e);
                end
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        v_i = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: ready_o never rose for epa %h", epa);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset_i && v_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: eva %h appeared with nothing expected", eva_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("eva", eva_o, mon_e.eva);
                chk("is_dram", {31'b0, is_dram_o}, {31'b0, mon_e.dram});
                chk("is_invalid", {31'b0, is_invalid_o}, {31'b0, mon_e.inv});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i       = 1'b1;
        v_i           = 1'b0;
        ready_i       = 1'b1;
        x_cord_i      = '0;
        y_cord_i      = '0;
        epa_i         = '0;
        dram_enable_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_i = 1'b0;
        @(negedge clk);
        chk("rst_v_o", {31'b0, v_o}, 32'd0);
        chk("rst_eva", eva_o, 32'd0);
        chk("rst_is_dram", {31'b0, is_dram_o}, 32'd0);
        chk("rst_is_invalid", {31'b0, is_invalid_o}, 32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
        @(posedge clk);
        #1;

        // Global, with exact two-cycle latency
        send(6'd3, 6'd2, 28'h0000010, 1'b1, 32'h420C0040, 1'b0, 1'b0, 1);
        @(negedge clk);
        chk("latency_cycle1_v_o", {31'b0, v_o}, 32'd0);
        @(negedge clk);
        chk("latency_cycle2_v_o", {31'b0, v_o}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send(6'd5,  6'd9,  28'h000002B, 1'b1, 32'h800016AC, 1'b1, 1'b0, 1);
        send(6'd2,  6'd0,  28'h0000123, 1'b0, 32'h8000848C, 1'b1, 1'b0, 1);
        send(6'd0,  6'd1,  28'h8000004, 1'b0, 32'hC0000010, 1'b1, 1'b0, 1);
        send(6'd0,  6'd1,  28'h8000004, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
        send(6'd1,  6'd0,  28'h1000000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
        send(6'd0,  6'd9,  28'h0001000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1);
        send(6'd16, 6'd0,  28'h0000020, 1'b1, 32'h40400080, 1'b0, 1'b0, 1);
        send(6'd0,  6'd10, 28'h0000005, 1'b1, 32'h4A000014, 1'b0, 1'b0, 1);
        send(6'd15, 6'd0,  28'h0FFFFFF, 1'b1, 32'hFFFFFDFC, 1'b1, 1'b0, 1);
        send(6'd3,  6'd2,  28'h000FFFF, 1'b1, 32'h420FFFFC, 1'b0, 1'b0, 1);
        send(6'd3,  6'd2,  28'h0010000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1);
        send(6'd1,  6'd1,  28'h8000004, 1'b0, 32'h00000000, 1'b0, 1'b1, 1);
        wait_drain();
        @(posedge clk);
        #1;

        // Back-pressure: four globals, ready_i low for three cycles mid-stream
        fork
            begin
                send(6'd1, 6'd3, 28'h0000100, 1'b1, 32'h43040400, 1'b0, 1'b0, 1);
                send(6'd2, 6'd3, 28'h0000200, 1'b1, 32'h43080800, 1'b0, 1'b0, 1);
                send(6'd3, 6'd3, 28'h0000300, 1'b1, 32'h430C0C00, 1'b0, 1'b0, 1);
                send(6'd4, 6'd3, 28'h0000400, 1'b1, 32'h43101000, 1'b0, 1'b0, 1);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = v_o;
                end
                chk("stream_first_out", {31'b0, seen}, 32'd1);
                @(posedge clk);
                #1 ready_i = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_ready_o", {31'b0, ready_o}, 32'd0);
                    chk("stall_v_o", {31'b0, v_o}, 32'd1);
                    chk("stall_eva_hold", eva_o, 32'h43080800);
                end
                @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        wait_drain();
        @(posedge clk);
        #1;

        // Asynchronous reset with two NPAs in flight
        send(6'd7, 6'd4, 28'h0000011, 1'b1, 32'h0, 1'b0, 1'b0, 0);
        send(6'd8, 6'd4, 28'h0000022, 1'b1, 32'h0, 1'b0, 1'b0, 0);
        chk("pre_reset_v_o", {31'b0, v_o}, 32'd1);
        #1 reset_i = 1'b1;
        #1;
        chk("async_reset_v_o", {31'b0, v_o}, 32'd0);
        chk("async_reset_eva", eva_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_v_o", {31'b0, v_o}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(6'd3, 6'd2, 28'h0000010, 1'b1, 32'h420C0040, 1'b0, 1'b0, 1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
